hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipelined RV32I core. It drives hold and bubble-insert controls into the IF/DE, DE/EX (control and data), EX/ME and ME/WB pipeline registers. It resolves three hazards:
- load-use data hazards
- taken-branch/jump control hazards
- multi-cycle data-memory wait states
It also keeps stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/perf_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and the control unit.
package hazard_pkg;

  // RUDataWrSrc encoding selecting data-memory read data for writeback (marks a load).
  localparam logic [1:0] RUSRC_DM = 2'b01;

  // Data-memory wait-state machine.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wait_state_e;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with synchronous reset and clear; reset beats clear beats increment.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count qualifying cycles; a clear in the same cycle as an event drops the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, taken-branch and
// multi-cycle data-memory hazards, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DM_WAIT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             rs1_use_de,
  input  logic             rs2_use_de,
  input  logic [4:0]       rd_ex,
  input  logic             RuWr_ex,
  input  logic [1:0]       RUDataWrSrc_ex,
  input  logic             branch_taken_ex,
  input  logic             dm_access_me,
  input  logic             perf_clr,
  output logic             stall_fe,
  output logic             stall_de,
  output logic             stall_ex,
  output logic             stall_me,
  output logic             flush_de,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Counter is kept at least one bit wide so DM_WAIT = 0 still elaborates cleanly.
  localparam int unsigned CntW     = (DM_WAIT > 0) ? $clog2(DM_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'((DM_WAIT > 0) ? (DM_WAIT - 1) : 0);
  localparam bit DmWaitEn = (DM_WAIT != 0);

  wait_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_stall;

  logic            is_load_ex;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            load_use;
  logic            any_stall;
  logic            branch_flush;

  // Load in EX whose destination is read by DE; x0 never creates a dependency.
  assign is_load_ex = RuWr_ex && (RUDataWrSrc_ex == RUSRC_DM) && (rd_ex != 5'd0);
  assign rs1_hit    = rs1_use_de && (rs1_de == rd_ex);
  assign rs2_hit    = rs2_use_de && (rs2_de == rd_ex);
  assign load_use   = is_load_ex && (rs1_hit || rs2_hit);

  // Wait FSM: each DM access holds ME for DM_WAIT cycles, then one release cycle in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (dm_access_me && DmWaitEn) begin
          mem_stall = 1'b1;
          cnt_d     = CntLoad;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - CntW'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Wait FSM state; reset aborts any wait in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prioritised pipeline controls: reset, memory wait, taken branch, load-use bubble.
  always_comb begin
    stall_fe = 1'b0;
    stall_de = 1'b0;
    stall_ex = 1'b0;
    stall_me = 1'b0;
    flush_de = 1'b0;
    flush_ex = 1'b0;
    flush_wb = 1'b0;
    if (rst) begin
      flush_de = 1'b1;
      flush_ex = 1'b1;
      flush_wb = 1'b1;
    end else if (mem_stall) begin
      // Whole front of the pipe freezes; WB receives a bubble while ME waits.
      stall_fe = 1'b1;
      stall_de = 1'b1;
      stall_ex = 1'b1;
      stall_me = 1'b1;
      flush_wb = 1'b1;
    end else if (branch_taken_ex) begin
      // Squashes the dependent instruction too, so a coincident load-use is moot.
      flush_de = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_fe = 1'b1;
      stall_de = 1'b1;
      flush_ex = 1'b1;
    end
  end

  assign any_stall    = stall_fe || stall_de || stall_ex || stall_me;
  assign branch_flush = !rst && !mem_stall && branch_taken_ex;

  perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (any_stall),
    .count (stall_cycles)
  );

  perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (branch_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed vectors and queues the
// hand-computed response; a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

  // Output vector order: {stall_fe, stall_de, stall_ex, stall_me, flush_de, flush_ex, flush_wb}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_RST  = 7'b0000111;
  localparam logic [6:0] O_MEM  = 7'b1111001;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_LU   = 7'b1100010;

  typedef struct packed {
    logic [6:0]  o;
    logic [31:0] sc;
    logic [31:0] fe;
    logic [6:0]  bo;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_de = '0, rs2_de = '0, rd_ex = '0;
  logic       rs1_use_de = 1'b0, rs2_use_de = 1'b0, RuWr_ex = 1'b0;
  logic [1:0] RUDataWrSrc_ex = '0;
  logic       branch_taken_ex = 1'b0, dm_access_me = 1'b0, perf_clr = 1'b0;

  logic        a_sfe, a_sde, a_sex, a_sme, a_fde, a_fex, a_fwb;
  logic [31:0] a_sc, a_fe;
  logic        b_sfe, b_sde, b_sex, b_sme, b_fde, b_fex, b_fwb;
  logic [31:0] b_sc, b_fe;

  always #5 clk = ~clk;

  hazard_ctrl #(.DM_WAIT(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_use_de(rs1_use_de),
    .rs2_use_de(rs2_use_de), .rd_ex(rd_ex), .RuWr_ex(RuWr_ex),
    .RUDataWrSrc_ex(RUDataWrSrc_ex), .branch_taken_ex(branch_taken_ex),
    .dm_access_me(dm_access_me), .perf_clr(perf_clr), .stall_fe(a_sfe), .stall_de(a_sde),
    .stall_ex(a_sex), .stall_me(a_sme), .flush_de(a_fde), .flush_ex(a_fex), .flush_wb(a_fwb),
    .stall_cycles(a_sc), .flush_events(a_fe)
  );

  // Single-cycle memory variant: only reset and dm_access are driven.
  hazard_ctrl #(.DM_WAIT(0), .CNT_W(32)) u_dut_w0 (
    .clk(clk), .rst(rst), .rs1_de(5'd0), .rs2_de(5'd0), .rs1_use_de(1'b0),
    .rs2_use_de(1'b0), .rd_ex(5'd0), .RuWr_ex(1'b0), .RUDataWrSrc_ex(2'b00),
    .branch_taken_ex(1'b0), .dm_access_me(dm_access_me), .perf_clr(1'b0),
    .stall_fe(b_sfe), .stall_de(b_sde), .stall_ex(b_sex), .stall_me(b_sme),
    .flush_de(b_fde), .flush_ex(b_fex), .flush_wb(b_fwb), .stall_cycles(b_sc),
    .flush_events(b_fe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("outputs",       {25'd0, a_sfe, a_sde, a_sex, a_sme, a_fde, a_fex, a_fwb},
          {25'd0, e.o});
      chk("stall_cycles",  a_sc, e.sc);
      chk("flush_events",  a_fe, e.fe);
      chk("w0_outputs",    {25'd0, b_sfe, b_sde, b_sex, b_sme, b_fde, b_fex, b_fwb},
          {25'd0, e.bo});
      chk("w0_stall_cycles", b_sc, 32'd0);
    end
  end

  task automatic vec(input logic r, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic [1:0] src, input logic br, input logic dm,
                     input logic clr, input logic [6:0] eo, input int esc, input int efe);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1_de = rs1; rs1_use_de = u1; rs2_de = rs2; rs2_use_de = u2; rd_ex = rd;
    RuWr_ex = wr; RUDataWrSrc_ex = src; branch_taken_ex = br; dm_access_me = dm;
    perf_clr = clr;
    e.o  = eo;
    e.sc = 32'(esc);
    e.fe = 32'(efe);
    e.bo = r ? O_RST : O_NONE;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    //  rst rs1 u1 rs2 u2 rd wr src  br dm clr  expected     sc fe
    vec(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_RST,  0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 0, 0);
    vec(0, 5, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, O_LU,   0, 0);  // lw x5; use x5
    vec(0, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 1, 0);  // bubble in EX
    vec(0, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0, O_NONE, 1, 0);  // load to x0
    vec(0, 3, 1, 5, 0, 5, 1, 2'b01, 0, 0, 0, O_NONE, 1, 0);  // rs2 matches but unused
    vec(0, 3, 1, 7, 1, 7, 1, 2'b01, 0, 0, 0, O_LU,   1, 0);  // rs2 path
    vec(0, 5, 1, 0, 0, 5, 1, 2'b01, 1, 0, 0, O_BR,   2, 0);  // branch beats load-use
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 2, 1);
    vec(0, 5, 1, 0, 0, 5, 1, 2'b00, 0, 0, 0, O_NONE, 2, 1);  // ALU writer, not a load
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MEM,  2, 1);  // DM access held
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MEM,  3, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_NONE, 4, 1);  // release
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MEM,  4, 1);  // back-to-back retrigger
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_MEM,  5, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 6, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MEM,  6, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, O_MEM,  7, 1);  // branch masked, cnt=1
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, O_BR,   8, 1);  // branch on release
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 8, 2);
    vec(0, 5, 1, 0, 0, 5, 1, 2'b01, 0, 1, 0, O_MEM,  8, 2);  // mem wait beats load-use
    vec(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_RST,  9, 2);  // reset mid-WAIT
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 0, 0);  // back in RUN
    vec(0, 5, 1, 0, 0, 5, 1, 2'b01, 0, 0, 1, O_LU,   0, 0);  // clear beats stall count
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 0, 0);
    vec(0, 5, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, O_LU,   0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, O_BR,   1, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, O_NONE, 1, 1);  // clear nonzero counters
    vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
